pipelined_controlpath: RTL and testbench

Parametrised successor to the single-cycle controlpath. It accepts instructions over a valid/ready handshake, latches and decodes them into the ALU/copy control fields, and tracks in-flight ALU writes with a per-register scoreboard. Issue to the execution stage is withheld while a hazard exists. It sits between the instruction fetch/program-counter logic and the vector ALU datapath.

---
 rtl/pipelined_controlpath.sv | 146 ++++++++++++++
 tb/tb_pipelined_controlpath.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_controlpath.sv
// pipelined_controlpath: one-entry instruction hold register with valid/ready
// acceptance, field decode for the vector ALU, and a per-register countdown
// scoreboard that withholds issue while a source or destination is in flight.
module pipelined_controlpath #(
  parameter  int REG_AW   = 4,
  parameter  int ALU_LAT  = 3,
  parameter  int ZERO_REG = 0,
  localparam int INSTR_W  = 9 + 6 * REG_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [INSTR_W-1:0] instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              program_counter_inc,
  input  logic              flush,
  input  logic              exec_ready,
  output logic              ctrl_valid,
  output logic [2:0]        alu_op,
  output logic              alu_form,
  output logic [1:0]        alu_vec_perci,
  output logic              const_c,
  output logic [REG_AW-1:0] alu_a_select,
  output logic [REG_AW-1:0] alu_b_select,
  output logic [REG_AW-1:0] alu_c_select,
  output logic [REG_AW-1:0] alu_d_select,
  output logic [REG_AW-1:0] alu_Y1_select,
  output logic [REG_AW-1:0] alu_Y2_select,
  output logic [1:0]        alu_write,
  output logic              copy_neg,
  output logic [REG_AW-1:0] copy_select,
  output logic [REG_AW-1:0] zero_reg
);

  localparam int NREG  = 1 << REG_AW;
  localparam int CNT_W = $clog2(ALU_LAT + 1);
  // MSB position of the first register-select field (a)
  localparam int F_TOP = INSTR_W - 8;
  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);
  localparam logic [CNT_W-1:0]  LAT_CNT  = CNT_W'(ALU_LAT);

  logic                 held_r;
  logic [INSTR_W-1:0]   instr_r;
  logic                 copy_neg_r;
  logic [REG_AW-1:0]    copy_select_r;
  logic [CNT_W-1:0]     cnt_r [NREG];
  logic [NREG-1:0]      busy_s;
  logic [NREG-1:0]      set_s;
  logic                 hazard_s;
  logic                 valid_s;
  logic                 issue_s;
  logic                 ready_s;
  logic                 accept_s;

  // Field outputs come straight from the hold register, so they stay stable
  // for as long as the instruction sits un-issued.
  assign alu_op        = instr_r[INSTR_W-1 -: 3];
  assign alu_form      = instr_r[INSTR_W-4];
  assign alu_vec_perci = instr_r[INSTR_W-5 -: 2];
  assign const_c       = instr_r[INSTR_W-7];
  assign alu_a_select  = instr_r[F_TOP            -: REG_AW];
  assign alu_b_select  = instr_r[F_TOP - REG_AW   -: REG_AW];
  assign alu_c_select  = instr_r[F_TOP - 2*REG_AW -: REG_AW];
  assign alu_d_select  = instr_r[F_TOP - 3*REG_AW -: REG_AW];
  assign alu_Y1_select = instr_r[F_TOP - 4*REG_AW -: REG_AW];
  assign alu_Y2_select = instr_r[F_TOP - 5*REG_AW -: REG_AW];
  assign alu_write     = instr_r[1:0];
  assign copy_neg      = copy_neg_r;
  assign copy_select   = copy_select_r;
  assign zero_reg      = ZERO_IDX;

  assign ctrl_valid          = valid_s;
  assign instr_ready         = ready_s;
  assign program_counter_inc = accept_s;

  // A register is busy while its countdown is nonzero; the zero register never is.
  always_comb begin
    busy_s = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      busy_s[i] = (cnt_r[i] != {CNT_W{1'b0}}) && (REG_AW'(i) != ZERO_IDX);
    end
  end

  // Hazard check on the held word, then issue/ready/accept handshake terms.
  always_comb begin
    hazard_s = held_r & (busy_s[alu_a_select] | busy_s[alu_b_select] |
                         (~const_c & busy_s[alu_c_select]) | busy_s[alu_d_select] |
                         (alu_write[0] & busy_s[alu_Y1_select]) |
                         (alu_write[1] & busy_s[alu_Y2_select]));
    valid_s  = held_r & ~hazard_s & ~flush;
    issue_s  = valid_s & exec_ready;
    // Gated by reset_n so nothing is accepted or pulsed while reset is asserted.
    ready_s  = reset_n & (~held_r | issue_s);
    accept_s = instr_valid & ready_s;
  end

  // Destinations whose countdown is (re)loaded by the instruction issuing now.
  always_comb begin
    set_s = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      set_s[i] = issue_s && (REG_AW'(i) != ZERO_IDX) &&
                 ((alu_write[0] && (alu_Y1_select == REG_AW'(i))) ||
                  (alu_write[1] && (alu_Y2_select == REG_AW'(i))));
    end
  end

  // Hold register: a new word replaces the issued/flushed one; copy fields decoded on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_r        <= 1'b0;
      instr_r       <= {INSTR_W{1'b0}};
      copy_neg_r    <= 1'b0;
      copy_select_r <= {REG_AW{1'b0}};
    end else if (accept_s) begin
      held_r        <= 1'b1;
      instr_r       <= instruction;
      copy_neg_r    <= (instruction[INSTR_W-1 -: 3] == 3'b111) ? instruction[INSTR_W-4] : 1'b0;
      copy_select_r <= (instruction[INSTR_W-1 -: 3] == 3'b111) ? instruction[F_TOP -: REG_AW]
                                                               : {REG_AW{1'b0}};
    end else if (issue_s || flush) begin
      held_r <= 1'b0;
    end else begin
      held_r <= held_r;
    end
  end

  // Scoreboard countdowns: load on issue (load beats decrement), else count down to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (set_s[i]) begin
          cnt_r[i] <= LAT_CNT;
        end else if (cnt_r[i] != {CNT_W{1'b0}}) begin
          cnt_r[i] <= cnt_r[i] - CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_controlpath.sv
// Self-checking bench for pipelined_controlpath: directed scenarios followed by
// random traffic, all compared against a cycle-count reference model.
module tb_pipelined_controlpath;

  localparam int REG_AW  = 4;
  localparam int ALU_LAT = 3;

  typedef struct packed {
    logic [2:0] op;
    logic       form;
    logic [1:0] pc;
    logic       cc;
    logic [3:0] a, b, c, d, y1, y2;
    logic [1:0] wr;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [32:0] instruction;
  logic        instr_valid, flush, exec_ready;
  logic        instr_ready, program_counter_inc, ctrl_valid;
  logic [2:0]  alu_op;
  logic        alu_form, const_c, copy_neg;
  logic [1:0]  alu_vec_perci, alu_write;
  logic [3:0]  alu_a_select, alu_b_select, alu_c_select, alu_d_select;
  logic [3:0]  alu_Y1_select, alu_Y2_select, copy_select, zero_reg;
  logic [37:0] fields_obs;

  pipelined_controlpath #(.REG_AW(REG_AW), .ALU_LAT(ALU_LAT), .ZERO_REG(0)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .program_counter_inc(program_counter_inc), .flush(flush),
    .exec_ready(exec_ready), .ctrl_valid(ctrl_valid), .alu_op(alu_op), .alu_form(alu_form),
    .alu_vec_perci(alu_vec_perci), .const_c(const_c), .alu_a_select(alu_a_select),
    .alu_b_select(alu_b_select), .alu_c_select(alu_c_select), .alu_d_select(alu_d_select),
    .alu_Y1_select(alu_Y1_select), .alu_Y2_select(alu_Y2_select), .alu_write(alu_write),
    .copy_neg(copy_neg), .copy_select(copy_select), .zero_reg(zero_reg)
  );

  always #5 clk = ~clk;

  assign fields_obs = {alu_op, alu_form, alu_vec_perci, const_c, alu_a_select, alu_b_select,
                       alu_c_select, alu_d_select, alu_Y1_select, alu_Y2_select, alu_write,
                       copy_neg, copy_select};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a held word plus, per register, the first cycle it is readable again.
  bit          m_held;
  instr_t      m_word;
  int          free_at [16];
  int          cyc;
  bit          s_issue, s_acc, s_f;
  logic [32:0] s_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] mk(input logic [2:0] op, input logic form, input logic [1:0] pc,
                                     input logic cc, input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] c, input logic [3:0] d, input logic [3:0] y1,
                                     input logic [3:0] y2, input logic [1:0] wr);
    return {op, form, pc, cc, a, b, c, d, y1, y2, wr};
  endfunction

  function automatic bit mbusy(input logic [3:0] r);
    return (r != 4'd0) && (cyc < free_at[r]);
  endfunction

  // Drive one cycle's inputs, let them settle mid-cycle, compare against the model.
  task automatic settle(input logic v, input logic [32:0] w, input logic f, input logic e);
    bit hz, e_valid, e_ready;
    logic [37:0] exp_f;
    instr_valid = v; instruction = w; flush = f; exec_ready = e;
    #3;
    hz = m_held && (mbusy(m_word.a) || mbusy(m_word.b) || (!m_word.cc && mbusy(m_word.c)) ||
                    mbusy(m_word.d) || (m_word.wr[0] && mbusy(m_word.y1)) ||
                    (m_word.wr[1] && mbusy(m_word.y2)));
    e_valid = m_held && !hz && !f;
    s_issue = e_valid && e;
    e_ready = !m_held || s_issue;
    s_acc   = v && e_ready;
    s_f     = f;
    s_w     = w;
    chk("ctrl_valid", 64'(ctrl_valid), 64'(e_valid));
    chk("instr_ready", 64'(instr_ready), 64'(e_ready));
    chk("pc_inc", 64'(program_counter_inc), 64'(s_acc));
    if (m_held) begin
      exp_f = {m_word.op, m_word.form, m_word.pc, m_word.cc, m_word.a, m_word.b, m_word.c,
               m_word.d, m_word.y1, m_word.y2, m_word.wr,
               (m_word.op == 3'b111) ? m_word.form : 1'b0,
               (m_word.op == 3'b111) ? m_word.a : 4'd0};
      chk("fields", 64'(fields_obs), 64'(exp_f));
    end
  endtask

  // Advance one clock and apply that cycle's outcome to the model.
  task automatic tick();
    @(posedge clk); #1;
    if (s_issue) begin
      if (m_word.wr[0] && m_word.y1 != 4'd0) free_at[m_word.y1] = cyc + ALU_LAT + 1;
      if (m_word.wr[1] && m_word.y2 != 4'd0) free_at[m_word.y2] = cyc + ALU_LAT + 1;
    end
    if (s_acc) begin
      m_held = 1'b1;
      m_word = s_w;
    end else if (s_issue || s_f) begin
      m_held = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_cycle(input logic v, input logic [32:0] w, input logic f, input logic e);
    settle(v, w, f, e);
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 33'd0, 1'b0, 1'b1);
  endtask

  // Count cycles the held word waits before ctrl_valid; -1 if the bound expires.
  task automatic wait_valid(output int n);
    n = -1;
    for (int k = 0; k < 20; k++) begin
      settle(1'b0, 33'd0, 1'b0, 1'b1);
      if (ctrl_valid === 1'b1) begin
        tick();
        n = k;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int n;
    logic [32:0] rw;
    m_held = 1'b0; cyc = 0;
    for (int i = 0; i < 16; i++) free_at[i] = 0;

    // Reset with a valid word presented
    reset_n = 1'b0; instr_valid = 1'b1; instruction = {33{1'b1}}; flush = 1'b0; exec_ready = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    chk("rst_pc_inc", 64'(program_counter_inc), 64'd0);
    chk("rst_ready", 64'(instr_ready), 64'd0);
    chk("rst_valid", 64'(ctrl_valid), 64'd0);
    chk("rst_fields", 64'(fields_obs), 64'd0);
    chk("zero_reg", 64'(zero_reg), 64'd0);
    instr_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(instr_ready), 64'd1);
    @(posedge clk); #1;

    // Field decode of the reference word
    settle(1'b1, 33'b010_1_10_0_0001_0010_0011_0100_0101_0110_01, 1'b0, 1'b1);
    chk("first_pc_inc", 64'(program_counter_inc), 64'd1);
    tick();
    settle(1'b0, 33'd0, 1'b0, 1'b0);
    chk("dec_valid", 64'(ctrl_valid), 64'd1);
    chk("dec_op", 64'(alu_op), 64'd2);
    chk("dec_form", 64'(alu_form), 64'd1);
    chk("dec_perci", 64'(alu_vec_perci), 64'd2);
    chk("dec_abcd", 64'({alu_a_select, alu_b_select, alu_c_select, alu_d_select}), 64'h1234);
    chk("dec_y", 64'({alu_Y1_select, alu_Y2_select}), 64'h56);
    chk("dec_write", 64'(alu_write), 64'd1);
    chk("dec_copy", 64'({copy_neg, copy_select}), 64'd0);
    tick();
    idle(ALU_LAT + 2);

    // RAW: reader of r5 waits for the in-flight write
    do_cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 2'b01), 1'b0, 1'b1);
    do_cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 1'b0, 4'd5, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 2'b00), 1'b0, 1'b1);
    wait_valid(n);
    chk("raw_stall", 64'(n), 64'(ALU_LAT));
    idle(ALU_LAT + 2);

    // Independent follower issues back-to-back
    do_cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 2'b01), 1'b0, 1'b1);
    do_cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 1'b0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 2'b00), 1'b0, 1'b1);
    wait_valid(n);
    chk("indep_stall", 64'(n), 64'd0);
    idle(ALU_LAT + 2);

    // const_c masks the c operand
    do_cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 1'b0, 4'd1, 4'd2, 4'd4, 4'd4, 4'd3, 4'd6, 2'b01), 1'b0, 1'b1);
    do_cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 2'b00), 1'b0, 1'b1);
    wait_valid(n);
    chk("constc_stall", 64'(n), 64'd0);
    idle(ALU_LAT + 2);

    // Writes to r0 are never tracked
    do_cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 2'b11), 1'b0, 1'b1);
    do_cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b11), 1'b0, 1'b1);
    wait_valid(n);
    chk("zero_stall", 64'(n), 64'd0);
    idle(ALU_LAT + 2);

    // Backpressure: held word stays, no acceptance
    do_cycle(1'b1, mk(3'd3, 1'b1, 2'd1, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd12, 2'b01), 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      settle(1'b1, mk(3'd4, 1'b0, 2'd3, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 2'b10), 1'b0, 1'b0);
      chk("bp_ready", 64'(instr_ready), 64'd0);
      tick();
    end
    do_cycle(1'b0, 33'd0, 1'b0, 1'b1);
    idle(ALU_LAT + 2);

    // Flush drops the held word without touching the scoreboard
    do_cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd0, 2'b01), 1'b0, 1'b1);
    settle(1'b0, 33'd0, 1'b1, 1'b1);
    chk("flush_valid", 64'(ctrl_valid), 64'd0);
    tick();
    do_cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 1'b0, 4'd6, 4'd6, 4'd6, 4'd6, 4'd0, 4'd0, 2'b00), 1'b0, 1'b1);
    wait_valid(n);
    chk("flush_no_issue", 64'(n), 64'd0);
    // Flush with an empty hold register still accepts the incoming word
    settle(1'b1, mk(3'd2, 1'b0, 2'd0, 1'b0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 2'b00), 1'b1, 1'b1);
    chk("flush_acc_pc", 64'(program_counter_inc), 64'd1);
    tick();
    wait_valid(n);
    chk("flush_acc_kept", 64'(n), 64'd0);
    idle(ALU_LAT + 2);

    // Copy decode, then WAW on Y2=4
    do_cycle(1'b1, mk(3'b111, 1'b1, 2'd0, 1'b0, 4'd9, 4'd2, 4'd3, 4'd5, 4'd4, 4'd4, 2'b10), 1'b0, 1'b0);
    settle(1'b0, 33'd0, 1'b0, 1'b0);
    chk("copy_neg", 64'(copy_neg), 64'd1);
    chk("copy_sel", 64'(copy_select), 64'd9);
    tick();
    do_cycle(1'b1, mk(3'd1, 1'b0, 2'd0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd4, 2'b10), 1'b0, 1'b1);
    wait_valid(n);
    chk("waw_stall", 64'(n), 64'(ALU_LAT));
    idle(ALU_LAT + 2);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      rw = {1'($urandom_range(0, 1)), 32'($urandom)};
      do_cycle(1'($urandom_range(0, 3) != 0), rw, 1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 3) != 0));
    end

    // Reset mid-operation clears everything without a pc pulse
    instr_valid = 1'b1;
    reset_n = 1'b0;
    #2;
    chk("mid_rst_valid", 64'(ctrl_valid), 64'd0);
    chk("mid_rst_pc", 64'(program_counter_inc), 64'd0);
    chk("mid_rst_fields", 64'(fields_obs), 64'd0);
    instr_valid = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    m_held = 1'b0;
    for (int i = 0; i < 16; i++) free_at[i] = 0;
    cyc++;
    for (int k = 0; k < 60; k++) begin
      rw = {1'($urandom_range(0, 1)), 32'($urandom)};
      do_cycle(1'($urandom_range(0, 1)), rw, 1'b0, 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
